// File: rtl/nios_mem_byte_packer.sv
// Packs a valid/ready byte stream little-endian into 32-bit words and writes them to the Nios RAM.
// Optional running checksum of written words is enabled by defining MEM_PACKER_CHECKSUM_EN.
module nios_mem_byte_packer #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [ADDR_W-1:0] m_address,
  output logic [3:0]        m_byteenable,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {StIdle, StFill, StWrite} state_e;

  localparam logic [ADDR_W:0] WcMax = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        lane_q;
  logic [3:0]        be_q, be_next;
  logic [31:0]       pack_q, pack_next;
  logic              last_pending_q;
  logic              accept, close_word;

  assign s_ready    = (state_q == StFill);
  assign accept     = s_valid & s_ready;
  assign close_word = accept & ((lane_q == 2'd3) | s_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StFill;
      StFill:  if (close_word) state_d = StWrite;
      StWrite: state_d = last_pending_q ? StIdle : StFill;
      default: state_d = StIdle;
    endcase
  end

  // Merge the incoming byte into its lane of the word being assembled.
  always_comb begin
    pack_next = pack_q;
    be_next   = be_q;
    unique case (lane_q)
      2'd0: begin pack_next[7:0]   = s_data; be_next[0] = 1'b1; end
      2'd1: begin pack_next[15:8]  = s_data; be_next[1] = 1'b1; end
      2'd2: begin pack_next[23:16] = s_data; be_next[2] = 1'b1; end
      2'd3: begin pack_next[31:24] = s_data; be_next[3] = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q         <= '0;
      lane_q         <= 2'd0;
      be_q           <= 4'd0;
      pack_q         <= 32'd0;
      last_pending_q <= 1'b0;
      m_address      <= '0;
      m_byteenable   <= 4'd0;
      m_chipselect   <= 1'b0;
      m_write        <= 1'b0;
      m_writedata    <= 32'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      word_count     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            addr_q         <= start_addr;
            lane_q         <= 2'd0;
            be_q           <= 4'd0;
            pack_q         <= 32'd0;
            last_pending_q <= 1'b0;
            word_count     <= '0;
            busy           <= 1'b1;
          end
        end
        StFill: begin
          if (accept) begin
            pack_q <= pack_next;
            be_q   <= be_next;
            lane_q <= lane_q + 2'd1;
          end
          // The word register feeds the RAM directly so the strobe is a clean full cycle.
          if (close_word) begin
            last_pending_q <= s_last;
            m_address      <= addr_q;
            m_byteenable   <= be_next;
            m_writedata    <= pack_next;
            m_chipselect   <= 1'b1;
            m_write        <= 1'b1;
          end
        end
        StWrite: begin
          m_chipselect <= 1'b0;
          m_write      <= 1'b0;
          m_byteenable <= 4'd0;
          m_writedata  <= 32'd0;
          addr_q       <= addr_q + 1'b1;
          lane_q       <= 2'd0;
          be_q         <= 4'd0;
          pack_q       <= 32'd0;
          if (word_count != WcMax) word_count <= word_count + 1'b1;
          if (last_pending_q) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_PACKER_CHECKSUM_EN
  logic [31:0] checksum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum_q <= 32'd0;
    end else if ((state_q == StIdle) && start) begin
      checksum_q <= 32'd0;
    end else if (state_q == StWrite) begin
      checksum_q <= checksum_q + m_writedata;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_nios_mem_byte_packer.sv
// Randomized self-checking bench for nios_mem_byte_packer against a queue-based session model.
module tb_nios_mem_byte_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] start_addr = 12'd0;
  logic [7:0]  s_data = 8'd0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [11:0] m_address;
  logic [3:0]  m_byteenable;
  logic        m_chipselect;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        busy;
  logic        done;
  logic [12:0] word_count;
  logic [31:0] checksum;

  nios_mem_byte_packer #(.ADDR_W(12)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_address(m_address), .m_byteenable(m_byteenable), .m_chipselect(m_chipselect),
    .m_write(m_write), .m_writedata(m_writedata), .busy(busy), .done(done),
    .word_count(word_count), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Session model: bytes are collected per word, a word is expected on the bus the cycle
  // after it closes, and done the cycle after the final word.
  bit          m_sess = 0;
  logic [7:0]  m_bytes[$];
  logic [11:0] m_addr = 0;
  bit          m_wr = 0;
  logic [11:0] m_wr_addr = 0;
  logic [3:0]  m_wr_be = 0;
  logic [31:0] m_wr_data = 0;
  bit          m_wr_last = 0;
  bit          m_done = 0;
  logic [12:0] m_wc = 0;
  logic [31:0] m_csum = 0;

  initial begin
    bit nw, nd;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_sess = 0; m_bytes.delete(); m_addr = 0; m_wr = 0; m_done = 0;
        m_wc = 0; m_csum = 0; m_wr_last = 0;
      end else begin
        nw = 0;
        nd = 0;
        if (m_wr) begin
          if (m_wc != 13'h1000) m_wc++;
          m_csum += m_wr_data;
          m_addr++;
          if (m_wr_last) begin m_sess = 0; nd = 1; end
        end else if (m_sess) begin
          if (s_valid) begin
            m_bytes.push_back(s_data);
            if (m_bytes.size() == 4 || s_last) begin
              nw = 1;
              m_wr_addr = m_addr;
              m_wr_be = 4'd0;
              m_wr_data = 32'd0;
              foreach (m_bytes[i]) begin
                m_wr_be[i] = 1'b1;
                m_wr_data[8*i +: 8] = m_bytes[i];
              end
              m_wr_last = s_last;
              m_bytes.delete();
            end
          end
        end else if (start) begin
          m_sess = 1; m_addr = start_addr; m_wc = 0; m_csum = 0; m_bytes.delete();
        end
        m_wr = nw;
        m_done = nd;
      end
    end
  end

  typedef struct {logic [11:0] a; logic [3:0] be; logic [31:0] d;} wr_t;
  wr_t log_q[$];

  initial begin
    bit prev;
    logic [31:0] exp_cs;
    prev = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
`ifdef MEM_PACKER_CHECKSUM_EN
        exp_cs = m_csum;
`else
        exp_cs = 32'd0;
`endif
        chk("s_ready", 32'(s_ready), 32'(m_sess && !m_wr));
        chk("m_write", 32'(m_write), 32'(m_wr));
        chk("m_chipselect", 32'(m_chipselect), 32'(m_wr));
        chk("busy", 32'(busy), 32'(m_sess));
        chk("done", 32'(done), 32'(m_done));
        chk("word_count", 32'(word_count), 32'(m_wc));
        chk("checksum", checksum, exp_cs);
        if (m_wr && m_write) begin
          chk("m_address", 32'(m_address), 32'(m_wr_addr));
          chk("m_byteenable", 32'(m_byteenable), 32'(m_wr_be));
          chk("m_writedata", m_writedata, m_wr_data);
        end
        if (m_write) log_q.push_back('{a: m_address, be: m_byteenable, d: m_writedata});
        if (prev) chk("m_write_single", 32'(m_write), 32'd0);
        prev = m_write;
      end else begin
        prev = 0;
      end
    end
  end

  task automatic do_start(input logic [11:0] a);
    start = 1'b1;
    start_addr = a;
    @(posedge clk); #1;
    start = 1'b0;
    start_addr = 12'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    int n;
    n = 0;
    s_valid = 1'b1; s_data = b; s_last = l;
    @(negedge clk);
    while (!s_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("ready_timeout", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0; s_data = 8'($urandom);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic check_write(input int idx, input logic [11:0] a, input logic [3:0] be,
                             input logic [31:0] d);
    if (idx >= log_q.size()) begin
      chk("write_present", 32'(log_q.size()), 32'(idx + 1));
    end else begin
      chk("lit_addr", 32'(log_q[idx].a), 32'(a));
      chk("lit_be", 32'(log_q[idx].be), 32'(be));
      chk("lit_data", log_q[idx].d, d);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, base;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle_cycle();

    // Single full word.
    log_q.delete();
    do_start(12'h010);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 1);
    wait_done();
    chk("s1_word_count", 32'(word_count), 32'd1);
`ifdef MEM_PACKER_CHECKSUM_EN
    chk("s1_checksum", checksum, 32'h44332211);
`else
    chk("s1_checksum", checksum, 32'd0);
`endif
    chk("s1_writes", 32'(log_q.size()), 32'd1);
    check_write(0, 12'h010, 4'hF, 32'h44332211);

    // Partial final word.
    log_q.delete();
    do_start(12'h020);
    for (int i = 1; i <= 6; i++) send_byte(8'(i), i == 6);
    wait_done();
    chk("s2_word_count", 32'(word_count), 32'd2);
    check_write(0, 12'h020, 4'hF, 32'h04030201);
    check_write(1, 12'h021, 4'h3, 32'h00000605);

    // Address wrap.
    log_q.delete();
    do_start(12'hFFF);
    for (int i = 0; i < 8; i++) send_byte(8'(8'hA0 + i), i == 7);
    wait_done();
    check_write(0, 12'hFFF, 4'hF, 32'hA3A2A1A0);
    check_write(1, 12'h000, 4'hF, 32'hA7A6A5A4);

    // Throttled input with a stray start mid-session.
    log_q.delete();
    do_start(12'h030);
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(8'h10 + i), i == 7);
      if (i == 1) begin
        start = 1'b1; start_addr = 12'h0AB;
        idle_cycle();
        start = 1'b0;
      end else begin
        idle_cycle();
      end
    end
    wait_done();
    chk("s4_writes", 32'(log_q.size()), 32'd2);
    check_write(0, 12'h030, 4'hF, 32'h13121110);
    check_write(1, 12'h031, 4'hF, 32'h17161514);

    // Reset with a half-built word.
    log_q.delete();
    do_start(12'h050);
    send_byte(8'h01, 0); send_byte(8'h02, 0);
    #3 reset = 1'b1;
    #1;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_write", 32'(m_write), 32'd0);
    chk("rst_m_cs", 32'(m_chipselect), 32'd0);
    chk("rst_m_be", 32'(m_byteenable), 32'd0);
    chk("rst_m_addr", 32'(m_address), 32'd0);
    chk("rst_m_data", m_writedata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    chk("rst_checksum", checksum, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle_cycle();
    chk("rst_no_write", 32'(log_q.size()), 32'd0);
    do_start(12'h100);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0); send_byte(8'hDD, 1);
    wait_done();
    check_write(0, 12'h100, 4'hF, 32'hDDCCBBAA);

    // Lane-0 last byte.
    log_q.delete();
    do_start(12'h200);
    send_byte(8'h5A, 1);
    wait_done();
    check_write(0, 12'h200, 4'h1, 32'h0000005A);

    // Random sessions checked cycle by cycle against the model.
    for (int s = 0; s < 30; s++) begin
      repeat ($urandom_range(0, 3)) idle_cycle();
      base = int'($urandom_range(0, 4095));
      len = int'($urandom_range(1, 13));
      do_start(12'(base));
      for (int i = 0; i < len; i++) begin
        start = ($urandom_range(0, 5) == 0);
        start_addr = 12'($urandom);
        if ($urandom_range(0, 2) == 0) idle_cycle();
        send_byte(8'($urandom), i == len - 1);
        start = 1'b0;
      end
      wait_done();
      chk("rnd_word_count", 32'(word_count), 32'((len + 3) / 4));
    end

    repeat (3) idle_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
